// File: rtl/sysarr_sched_ctrl_if.sv
// sysarr_sched_ctrl_if: host command and array/buffer control bundle for the systolic schedule controller
interface sysarr_sched_ctrl_if #(
  parameter int ARRAY_DIM = 8,
  parameter int ADDR_BW   = 8,
  parameter int WAW       = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1
);
  logic                 start;
  logic                 reuse_w;
  logic [ADDR_BW-1:0]   num_vec;
  logic                 busy;
  logic                 done;
  logic                 w_rd_en;
  logic [WAW-1:0]       w_rd_addr;
  logic [ARRAY_DIM-1:0] we_rl;
  logic                 x_rd_en;
  logic [ADDR_BW-1:0]   x_rd_addr;
  logic                 o_valid;
  logic [ADDR_BW-1:0]   o_wr_addr;
  modport master (
    output start, reuse_w, num_vec,
    input  busy, done, w_rd_en, w_rd_addr, we_rl, x_rd_en, x_rd_addr, o_valid, o_wr_addr
  );
  modport slave (
    input  start, reuse_w, num_vec,
    output busy, done, w_rd_en, w_rd_addr, we_rl, x_rd_en, x_rd_addr, o_valid, o_wr_addr
  );
endinterface

// File: rtl/sysarr_sched_ctrl.sv
// sysarr_sched_ctrl: weight reload, activation feed and output-valid tracking for a weight-stationary systolic array
module sysarr_sched_ctrl #(
  parameter int ARRAY_DIM = 8,
  parameter int PIPE_LAT  = 16,
  parameter int ADDR_BW   = 8
) (
  input logic              clk,
  input logic              rst,
  sysarr_sched_ctrl_if.slave bus
);
  localparam int WAW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int CW  = $clog2(ARRAY_DIM + 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} state_t;
  state_t               st;
  logic [ADDR_BW-1:0]   n;
  logic [ADDR_BW-1:0]   oc;
  logic [CW-1:0]        wc;
  logic [PIPE_LAT-1:0]  vsr;
  logic                 busy;
  logic                 done;
  logic                 w_en;
  logic [WAW-1:0]       w_addr;
  logic [ARRAY_DIM-1:0] we;
  logic                 x_en;
  logic [ADDR_BW-1:0]   x_addr;
  logic                 o_valid;
  assign o_valid       = vsr[PIPE_LAT-1];
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.w_rd_en   = w_en;
  assign bus.w_rd_addr = w_addr;
  assign bus.we_rl     = we;
  assign bus.x_rd_en   = x_en;
  assign bus.x_rd_addr = x_addr;
  assign bus.o_valid   = o_valid;
  assign bus.o_wr_addr = oc;
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      n      <= '0;
      oc     <= '0;
      wc     <= '0;
      vsr    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      w_en   <= 1'b0;
      w_addr <= '0;
      we     <= '0;
      x_en   <= 1'b0;
      x_addr <= '0;
    end else begin
      // valid pipe mirrors the array latency in every state so output tracking overlaps FEED
      vsr <= (vsr << 1) | PIPE_LAT'(x_en);
      if (o_valid) oc <= oc + 1'b1;
      case (st)
        IDLE: if (bus.start && bus.num_vec != '0) begin
          n    <= bus.num_vec;
          busy <= 1'b1;
          oc   <= '0;
          wc   <= '0;
          if (bus.reuse_w) begin
            st     <= FEED;
            x_en   <= 1'b1;
            x_addr <= '0;
          end else begin
            st     <= LOAD_W;
            w_en   <= 1'b1;
            w_addr <= '0;
          end
        end
        LOAD_W: begin
          wc     <= wc + 1'b1;
          w_en   <= wc < CW'(ARRAY_DIM - 1);
          w_addr <= (wc < CW'(ARRAY_DIM - 1)) ? w_addr + 1'b1 : '0;
          // strobe trails the read by one cycle to meet the buffer's read latency
          we     <= (wc == '0) ? ARRAY_DIM'(1) : we << 1;
          if (wc == CW'(ARRAY_DIM)) begin
            st     <= FEED;
            x_en   <= 1'b1;
            x_addr <= '0;
          end
        end
        FEED: if (x_addr == n - 1'b1) begin
          st     <= DRAIN;
          x_en   <= 1'b0;
          x_addr <= '0;
        end else begin
          x_addr <= x_addr + 1'b1;
        end
        DRAIN: if (o_valid && oc == n - 1'b1) begin
          st   <= DONE;
          done <= 1'b1;
        end
        DONE: begin
          st   <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sysarr_sched_ctrl.sv
// tb_sysarr_sched_ctrl: directed plus random jobs checked cycle by cycle against a timeline model
module tb_sysarr_sched_ctrl;
  localparam int D = 8;
  localparam int L = 16;
  localparam int AB = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit act = 0;
  int t0 = 0;
  int jn = 0;
  bit jr = 0;
  sysarr_sched_ctrl_if #(.ARRAY_DIM(D), .ADDR_BW(AB)) bus();
  sysarr_sched_ctrl #(.ARRAY_DIM(D), .PIPE_LAT(L), .ADDR_BW(AB)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  function automatic int fin();
    return (jr ? 0 : D + 1) + L + jn;
  endfunction
  function automatic bit exp_busy(input int c);
    return act && c >= t0 && (c - t0) <= fin();
  endfunction
  task automatic compare_all();
    int rel, off;
    bit b, we_on, w_on, x_on, o_on;
    b     = exp_busy(cyc);
    rel   = cyc - t0;
    off   = jr ? 0 : D + 1;
    w_on  = b && !jr && rel < D;
    we_on = b && !jr && rel >= 1 && rel <= D;
    x_on  = b && rel >= off && rel < off + jn;
    o_on  = b && rel >= off + L && rel < off + L + jn;
    chk("busy", int'(bus.busy), int'(b));
    chk("done", int'(bus.done), int'(b && rel == fin()));
    chk("w_rd_en", int'(bus.w_rd_en), int'(w_on));
    chk("we_rl", int'(bus.we_rl), we_on ? (1 << (rel - 1)) : 0);
    chk("x_rd_en", int'(bus.x_rd_en), int'(x_on));
    chk("o_valid", int'(bus.o_valid), int'(o_on));
    if (w_on) chk("w_rd_addr", int'(bus.w_rd_addr), rel);
    if (x_on) chk("x_rd_addr", int'(bus.x_rd_addr), rel - off);
    if (o_on) chk("o_wr_addr", int'(bus.o_wr_addr), rel - off - L);
  endtask
  task automatic step(input bit r, input bit s, input bit ru, input int nv);
    @(negedge clk);
    rst         = r;
    bus.start   = s;
    bus.reuse_w = ru;
    bus.num_vec = AB'(nv);
    if (r) act = 0;
    else if (!exp_busy(cyc) && s && nv != 0) begin
      act = 1;
      t0  = cyc + 1;
      jn  = nv;
      jr  = ru;
    end
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0);
  endtask
  initial begin
    bus.start   = 1'b0;
    bus.reuse_w = 1'b0;
    bus.num_vec = '0;
    step(1, 0, 0, 0);
    step(1, 1, 0, 5);
    chk("rst_w_rd_addr", int'(bus.w_rd_addr), 0);
    chk("rst_x_rd_addr", int'(bus.x_rd_addr), 0);
    chk("rst_o_wr_addr", int'(bus.o_wr_addr), 0);
    idle(3);
    step(0, 1, 0, 4);
    idle(40);
    step(0, 1, 1, 1);
    idle(25);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    idle(3);
    for (int i = 0; i < 90; i++) step(0, 1, 1, 3);
    idle(30);
    step(0, 1, 0, 8);
    idle(11);
    step(1, 0, 0, 0);
    idle(40);
    step(0, 1, 0, 2);
    idle(35);
    step(0, 1, 1, 255);
    idle(280);
    for (int i = 0; i < 4000; i++) begin
      int nv;
      nv = ($urandom % 8 == 0) ? 0 : (($urandom % 25 == 0) ? int'($urandom_range(100, 255)) : int'($urandom_range(1, 6)));
      step($urandom % 300 == 0, $urandom % 3 == 0, $urandom % 2 == 1, nv);
    end
    idle(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sysarr_sched_ctrl.md
# sysarr_sched_ctrl

Schedule controller for the weight-stationary ARRAY_DIM×ARRAY_DIM systolic array. It takes one tile job per start command. For each job it:
- reloads the stationary weights row by row through the per-row weight-reload strobes, unless the previous weights are reused;
- streams N input vectors from the activation buffer into the array's input skew logic;
- tracks the fixed array pipeline latency so it can flag each valid partial-sum row for the output buffer.

It sits between the host command interface and the array/buffer wrapper. It contains no arithmetic datapath of its own.

## Interface
- ARRAY_DIM, 8, rows/columns of the array; also the number of weight rows loaded per job
- PIPE_LAT, 16, cycles from x_rd_en to the matching output row valid at the array bottom (buffer read + skew + array + deskew)
- ADDR_BW, 8, activation/output buffer address width; max N = 2^ADDR_BW−1

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; sampled only when busy=0
- reuse_w  in  1  sampled with start; 1 = skip weight reload
- num_vec  in  ADDR_BW  N, vectors in the job; sampled with start
- busy  out  1  job in progress
- done  out  1  single-cycle end-of-job pulse
- w_rd_en  out  1  weight-buffer read enable
- w_rd_addr  out  clog2(ARRAY_DIM)  weight row index
- we_rl  out  ARRAY_DIM  one-hot row weight-reload strobes to the array
- x_rd_en  out  1  activation-buffer read enable
- x_rd_addr  out  ADDR_BW  activation vector index
- o_valid  out  1  array output row valid; write to output buffer
- o_wr_addr  out  ADDR_BW  output vector index

## Operation
- States: IDLE, LOAD_W, FEED, DRAIN, DONE.
- IDLE
  - start=1 and num_vec≠0: latch N and reuse_w, set busy.
    - Go to LOAD_W if reuse_w=0, else go to FEED.
  - start=1 and num_vec=0: ignored, stay IDLE, no done.
- LOAD_W: counter c runs 0..ARRAY_DIM, giving ARRAY_DIM+1 cycles.
  - c<ARRAY_DIM: w_rd_en=1, w_rd_addr=c.
  - c≥1: we_rl[c−1]=1. The weight buffer has 1-cycle read latency, so the strobe aligns with the data.
  - After c=ARRAY_DIM, go to FEED.
- FEED: N cycles with x_rd_en=1 and x_rd_addr=0..N−1, in order with no gaps. Then go to DRAIN.
- Output tracking:
  - A PIPE_LAT-deep valid shift register carries x_rd_en, so o_valid = x_rd_en delayed PIPE_LAT cycles.
  - An output counter supplies o_wr_addr=0..N−1 on each o_valid.
  - The shift register is active in every state, which lets output tracking overlap FEED.
- DRAIN: wait until the output counter reaches N (last o_valid issued), then go to DONE.
- DONE: assert done for one cycle, busy still 1; go to IDLE.
- start while busy=1 (including the DONE cycle) is ignored; it is not queued.
- At most one we_rl bit is high per cycle. we_rl is all-zero outside LOAD_W.
- Weights reloaded in one job stay valid for later reuse_w=1 jobs. The controller does not check that a prior load exists.

## Timing
- Reset (rst=1 at an edge) drives the following values at that edge:
  - outputs: busy, done, w_rd_en, x_rd_en, o_valid = 0; we_rl = 0; all addresses = 0;
  - internal: state = IDLE, valid shift register cleared, counters = 0.
- Reset mid-job aborts the job. No done is issued, and in-flight o_valid never appears.
- Let T0 be the first cycle after start is accepted, with D=ARRAY_DIM and L=PIPE_LAT.
- reuse_w=0:
  - LOAD_W: T0..T0+D.
  - FEED: T0+D+1..T0+D+N.
  - o_valid: T0+D+1+L..T0+D+L+N.
  - done: T0+D+L+N+1.
  - busy=0 from T0+D+L+N+2.
- reuse_w=1:
  - FEED: T0..T0+N−1.
  - o_valid: T0+L..T0+L+N−1.
  - done: T0+L+N.
- The next start is accepted in the first cycle with busy=0.
- N=2^ADDR_BW−1: counters must not wrap before the terminal compare.

## Test plan
- Defaults, reuse_w=0, N=4, start at T0−1 -> w_rd_addr 0..7 at T0..T7; we_rl one-hot 0x01..0x80 at T1..T8; x_rd_addr 0..3 at T9..T12; o_valid with o_wr_addr 0..3 at T25..T28; done at T29; busy low at T30.
- reuse_w=1, N=1 -> no w_rd_en or we_rl; x_rd_en at T0 only; o_valid at T16; done at T17.
- start with num_vec=0 -> busy stays 0; no done; all enables stay 0.
- start held high during a job and during the DONE cycle -> ignored; with start still high, the second job's T0 is 2 cycles after the first job's done pulse, since busy drops 1 cycle after done and start is accepted then.
- rst asserted in FEED (reuse_w=0, N=8, at T11) -> all outputs 0 from the next edge; no o_valid or done afterwards; a fresh job then runs with nominal timing.
- N=255 with reuse_w=1 -> 255 contiguous o_valid with o_wr_addr 0..254 and no wrap; done exactly at T0+16+255.
